// File: rtl/reg_dump_reader_pkg.sv
// Shared register-file constants and the dump reader state encoding.
package reg_dump_reader_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/reg_dump_reader.sv
// Debug-side register file dumper: walks register addresses in ascending
// order, snapshots each combinational read and streams (index, data) beats
// over a valid/ready handshake, closing with out_last and a done pulse.
module reg_dump_reader #(
  parameter int XLEN     = reg_dump_reader_pkg::XLEN,
  parameter int NUM_REGS = reg_dump_reader_pkg::NUM_REGS,
  parameter int ADDR_W   = reg_dump_reader_pkg::ADDR_W,
  parameter int SKIP_X0  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [XLEN-1:0]   rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_idx,
  output logic [XLEN-1:0]   out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  import reg_dump_reader_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'((SKIP_X0 != 0) ? 1 : 0);

  state_t            state_reg;
  state_t            state_next;
  logic [ADDR_W-1:0] idx_reg;
  logic [ADDR_W-1:0] out_idx_reg;
  logic [XLEN-1:0]   out_data_reg;
  logic              out_last_reg;

  assign out_idx  = out_idx_reg;
  assign out_data = out_data_reg;
  assign out_last = out_last_reg;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and Moore outputs; abort beats every other request.
  always_comb begin
    state_next = state_reg;
    rd_addr    = '0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start && !abort) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        rd_addr    = idx_reg;
        state_next = abort ? IDLE : SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        if (abort) begin
          state_next = IDLE;
        end else if (out_ready) begin
          state_next = out_last_reg ? DONE : FETCH;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Walk index and beat holding register; the beat is captured only at the
  // FETCH edge so later register writes cannot disturb a pending beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg      <= '0;
      out_idx_reg  <= '0;
      out_data_reg <= '0;
      out_last_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start && !abort) begin
            idx_reg <= FIRST_IDX;
          end
        end
        FETCH: begin
          out_data_reg <= rd_data;
          out_idx_reg  <= idx_reg;
          out_last_reg <= (idx_reg == LAST_IDX);
        end
        SEND: begin
          if (out_ready && !out_last_reg) begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: two instances (x0 included / skipped)
// read a shared behavioural register file.
module tb_reg_dump_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b1;
  logic        preload = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rf [32];

  logic [4:0]  rd_addr0, rd_addr1, out_idx0, out_idx1;
  logic [31:0] rd_data0, rd_data1, out_data0, out_data1;
  logic        out_valid0, out_valid1, out_last0, out_last1;
  logic        busy0, busy1, done0, done1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural register file: synchronous write, combinational read.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'hA000_0000 + i;
    end else if (wr_en) begin
      rf[wr_addr] <= wr_data;
    end
  end
  assign rd_data0 = rf[rd_addr0];
  assign rd_data1 = rf[rd_addr1];

  reg_dump_reader #(.SKIP_X0(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort),
    .rd_addr(rd_addr0), .rd_data(rd_data0), .out_valid(out_valid0),
    .out_ready(out_ready), .out_idx(out_idx0), .out_data(out_data0),
    .out_last(out_last0), .busy(busy0), .done(done0));

  reg_dump_reader #(.SKIP_X0(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort),
    .rd_addr(rd_addr1), .rd_data(rd_data1), .out_valid(out_valid1),
    .out_ready(out_ready), .out_idx(out_idx1), .out_data(out_data1),
    .out_last(out_last1), .busy(busy1), .done(done1));

  // Beat monitors: record accepted beats, done pulses and timing stamps.
  logic [4:0]  q0_idx[$], q1_idx[$];
  logic [31:0] q0_data[$], q1_data[$];
  logic        q0_last[$], q1_last[$];
  int done0_cnt = 0, done1_cnt = 0;
  int fetch0_cyc = 0, fv0_cyc = -1, done0_cyc = 0;
  logic busy0_d = 1'b0;

  always @(negedge clk) begin
    if (busy0 && !busy0_d) begin
      fetch0_cyc = cyc;
      fv0_cyc = -1;
    end
    if (out_valid0 && fv0_cyc < 0) fv0_cyc = cyc;
    busy0_d = busy0;
    if (out_valid0 && out_ready) begin
      q0_idx.push_back(out_idx0);
      q0_data.push_back(out_data0);
      q0_last.push_back(out_last0);
    end
    if (done0) begin
      done0_cnt++;
      done0_cyc = cyc;
    end
  end

  always @(negedge clk) begin
    if (out_valid1 && out_ready) begin
      q1_idx.push_back(out_idx1);
      q1_data.push_back(out_data1);
      q1_last.push_back(out_last1);
    end
    if (done1) done1_cnt++;
  end

  task automatic do_preload();
    @(posedge clk); #1 preload = 1'b1;
    @(posedge clk); #1 preload = 1'b0;
  endtask

  task automatic pulse_start0();
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
  endtask

  task automatic wait_done0(input int base, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #1;
      if (done0_cnt > base) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_beat0(input logic [4:0] idx, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (out_valid0 && out_idx0 == idx) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid0, out_last0, busy0, done0} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {out_valid0, out_last0, busy0, done0});
    end
    checks++;
    if ({rd_addr0, out_idx0, out_data0} !== 42'd0) begin
      errors++; $display("FAIL reset_data got %h/%h/%h want 0", rd_addr0, out_idx0, out_data0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    do_preload();
    $display("reset: outputs checked");
  endtask

  task automatic test_full_dump();
    int base = q0_idx.size();
    int dbase = done0_cnt;
    int bad = 0;
    bit ok;
    pulse_start0();
    wait_done0(dbase, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL full_done timeout got none want done"); end
    checks++;
    if (q0_idx.size() - base != 32) begin
      errors++; $display("FAIL full_count got %0d want 32", q0_idx.size() - base);
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (q0_idx[base+i] !== 5'(i) || q0_data[base+i] !== 32'hA000_0000 + i ||
            q0_last[base+i] !== (i == 31)) bad++;
      end
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL full_beats got %0d bad beats want 0", bad); end
    checks++;
    if (done0_cyc - fetch0_cyc != 64) begin
      errors++; $display("FAIL full_latency got %0d want 64", done0_cyc - fetch0_cyc);
    end
    checks++;
    if (fv0_cyc - fetch0_cyc != 1) begin
      errors++; $display("FAIL first_valid got %0d want 1", fv0_cyc - fetch0_cyc);
    end
    checks++;
    if (done0_cnt - dbase != 1) begin
      errors++; $display("FAIL full_done_cnt got %0d want 1", done0_cnt - dbase);
    end
    $display("full dump: %0d beats, %0d cycles fetch->done", q0_idx.size() - base, done0_cyc - fetch0_cyc);
  endtask

  task automatic test_skip_x0();
    int base = q1_idx.size();
    int dbase = done1_cnt;
    bit ok = 1'b0;
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (done1_cnt > dbase) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || q1_idx.size() - base != 31) begin
      errors++; $display("FAIL skip_count got %0d want 31", q1_idx.size() - base);
    end else begin
      checks++;
      if (q1_idx[base] !== 5'd1 || q1_data[base] !== 32'hA000_0001 || q1_last[base] !== 1'b0) begin
        errors++; $display("FAIL skip_first got %h/%h want 01/a0000001", q1_idx[base], q1_data[base]);
      end
      checks++;
      if (q1_idx[base+30] !== 5'd31 || q1_last[base+30] !== 1'b1) begin
        errors++; $display("FAIL skip_last got %h/%b want 1f/1", q1_idx[base+30], q1_last[base+30]);
      end
    end
    $display("skip x0: %0d beats", q1_idx.size() - base);
  endtask

  task automatic test_stall();
    int base = q0_idx.size();
    int dbase = done0_cnt;
    int bad = 0;
    bit ok;
    pulse_start0();
    wait_beat0(5'd2, ok);
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (out_valid0 !== 1'b1 || out_idx0 !== 5'd3 || out_data0 !== 32'hA000_0003) bad++;
    end
    checks++;
    if (!ok || bad != 0) begin
      errors++; $display("FAIL stall_hold got %0d unstable cycles (found=%0d) want 0", bad, ok);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_done0(dbase, 200, ok);
    checks++;
    if (!ok || q0_idx.size() - base != 32 || q0_idx[base+3] !== 5'd3 ||
        q0_idx[base+4] !== 5'd4 || q0_data[base+4] !== 32'hA000_0004) begin
      errors++; $display("FAIL stall_resume got count %0d want 32 with beat4=a0000004", q0_idx.size() - base);
    end
    $display("stall: idx3 held 5 cycles, %0d beats", q0_idx.size() - base);
  endtask

  task automatic test_snapshot();
    int base = q0_idx.size();
    int dbase = done0_cnt;
    bit ok;
    pulse_start0();
    wait_beat0(5'd6, ok);
    @(posedge clk); #1 wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEAD_BEEF;
    @(posedge clk); #1 wr_en = 1'b0;
    wait_done0(dbase, 200, ok);
    checks++;
    if (!ok || q0_idx.size() - base != 32 || q0_data[base+7] !== 32'hA000_0007) begin
      errors++; $display("FAIL snap_old got %h want a0000007", (q0_idx.size() - base > 7) ? q0_data[base+7] : 32'h0);
    end
    base = q0_idx.size();
    dbase = done0_cnt;
    pulse_start0();
    wait_done0(dbase, 200, ok);
    checks++;
    if (!ok || q0_idx.size() - base != 32 || q0_data[base+7] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL snap_new got %h want deadbeef", (q0_idx.size() - base > 7) ? q0_data[base+7] : 32'h0);
    end
    do_preload();
    $display("snapshot: same-edge write hidden, repeat dump sees it");
  endtask

  task automatic test_abort();
    int base = q0_idx.size();
    int dbase = done0_cnt;
    bit ok;
    pulse_start0();
    wait_beat0(5'd10, ok);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    checks++;
    if (!ok || out_valid0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++; $display("FAIL abort_idle got valid=%b busy=%b want 0/0", out_valid0, busy0);
    end
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (done0_cnt != dbase || q0_idx.size() - base != 11) begin
      errors++; $display("FAIL abort_beats got dones=%0d beats=%0d want 0/11", done0_cnt - dbase, q0_idx.size() - base);
    end
    base = q0_idx.size();
    pulse_start0();
    wait_done0(dbase, 200, ok);
    checks++;
    if (!ok || q0_idx.size() - base != 32 || q0_idx[base] !== 5'd0) begin
      errors++; $display("FAIL abort_restart got count %0d want 32 from idx 0", q0_idx.size() - base);
    end
    $display("abort: stopped after idx 10, restart from 0");
  endtask

  task automatic test_start_busy();
    int base = q0_idx.size();
    int dbase = done0_cnt;
    int bad = 0;
    bit ok;
    pulse_start0();
    wait_beat0(5'd5, ok);
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    wait_done0(dbase, 200, ok);
    if (q0_idx.size() - base == 32)
      for (int i = 0; i < 32; i++) if (q0_idx[base+i] !== 5'(i)) bad++;
    checks++;
    if (!ok || q0_idx.size() - base != 32 || bad != 0 || done0_cnt - dbase != 1) begin
      errors++; $display("FAIL start_busy got count %0d bad %0d want 32/0", q0_idx.size() - base, bad);
    end
    $display("start while busy: ignored, %0d beats", q0_idx.size() - base);
  endtask

  task automatic test_reset_mid_walk();
    bit ok;
    pulse_start0();
    wait_beat0(5'd12, ok);
    checks++;
    if (!ok || out_data0 !== 32'hA000_000C) begin
      errors++; $display("FAIL mid_pre got %h want a000000c", out_data0);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid0, out_last0, busy0, done0} !== 4'b0 || {rd_addr0, out_idx0, out_data0} !== 42'd0) begin
      errors++; $display("FAIL mid_reset got v=%b b=%b idx=%h data=%h want all 0", out_valid0, busy0, out_idx0, out_data0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b0) begin errors++; $display("FAIL mid_after got busy=%b want 0", busy0); end
    $display("reset mid walk: outputs cleared asynchronously");
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_skip_x0();
    test_stall();
    test_snapshot();
    test_abort();
    test_start_busy();
    test_reset_mid_walk();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
